// File: rtl/rs_pkg.sv
// rs_pkg: shared reservation-station sizing constants and entry index type
package rs_pkg;
  localparam int RS_WIDTH = 16;
  localparam int DISPATCH_WIDTH = 3;
  localparam int RS_IDX_W = $clog2(RS_WIDTH);
  localparam int RS_CNT_W = $clog2(RS_WIDTH + 1);
  typedef logic [RS_IDX_W-1:0] rs_idx_t;
endpackage

// File: rtl/onehot_enc.sv
// onehot_enc: one-hot (or zero) vector to binary index plus valid; index is 0 when no bit set
module onehot_enc import rs_pkg::*; #(
  parameter int W = RS_WIDTH,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  assign o_valid = |i_onehot;
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < W; i++) if (i_onehot[i]) o_idx = o_idx | IW'(i);
  end
endmodule

// File: rtl/rs_free_tracker.sv
// rs_free_tracker: RS free-entry vector with grant-driven allocation, release, flush and stall.
// Define RS_FREE_TRACKER_CHECK_EN to enable the sticky protocol error flag o_err.
module rs_free_tracker import rs_pkg::*; #(
  parameter int WIDTH = RS_WIDTH,
  parameter int REQS = DISPATCH_WIDTH,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  output logic [WIDTH-1:0]        o_free_vec,
  input  logic [REQS*WIDTH-1:0]   i_gnt_bus,
  input  logic [REQS-1:0]         i_alloc_valid,
  output logic [REQS-1:0]         o_alloc_ok,
  output logic [REQS*IDX_W-1:0]   o_alloc_idx,
  input  logic [WIDTH-1:0]        i_release_mask,
  input  logic                    i_flush,
  output logic [CNT_W-1:0]        o_free_cnt,
  output logic                    o_stall,
  output logic                    o_err
);
  logic [WIDTH-1:0] w_slice [REQS];
  logic [REQS-1:0]  w_ok;
  logic [WIDTH-1:0] w_alloc_mask, w_next, r_free;
  logic [CNT_W-1:0] r_cnt;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) popcnt = popcnt + CNT_W'(v[i]);
  endfunction

  for (genvar k = 0; k < REQS; k++) begin : g_slot
    assign w_slice[k] = i_gnt_bus[(k+1)*WIDTH-1 -: WIDTH];
    onehot_enc #(.W(WIDTH), .IW(IDX_W)) u_enc (
      .i_onehot(w_slice[k]),
      .o_idx   (o_alloc_idx[k*IDX_W +: IDX_W]),
      .o_valid (w_ok[k])
    );
  end
  assign o_alloc_ok = w_ok;

  always_comb begin
    w_alloc_mask = '0;
    for (int k = 0; k < REQS; k++) w_alloc_mask = w_alloc_mask | (w_slice[k] & {WIDTH{i_alloc_valid[k]}});
  end
  // release is OR-ed after the alloc clear so it wins on a shared bit
  assign w_next = i_flush ? '1 : (r_free & ~w_alloc_mask) | i_release_mask;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_free <= '1;
      r_cnt  <= CNT_W'(WIDTH);
    end else begin
      r_free <= w_next;
      r_cnt  <= popcnt(w_next);
    end
  end

  assign o_free_vec = r_free;
  assign o_free_cnt = r_cnt;
  assign o_stall    = int'(r_cnt) < REQS;

`ifdef RS_FREE_TRACKER_CHECK_EN
  logic             w_multi, w_overlap, w_busy_gnt, w_dup_rel, w_not_therm, w_no_gnt, w_bad, r_err;
  logic [WIDTH-1:0] w_seen;
  always_comb begin
    w_multi    = 1'b0;
    w_overlap  = 1'b0;
    w_busy_gnt = 1'b0;
    w_seen     = '0;
    for (int k = 0; k < REQS; k++) begin
      w_multi    = w_multi | (|(w_slice[k] & (w_slice[k] - WIDTH'(1))));
      w_overlap  = w_overlap | (|(w_slice[k] & w_seen));
      w_busy_gnt = w_busy_gnt | (|(w_slice[k] & ~r_free));
      w_seen     = w_seen | w_slice[k];
    end
  end
  assign w_dup_rel   = |(i_release_mask & r_free);
  assign w_not_therm = |(i_alloc_valid & (i_alloc_valid + REQS'(1)));
  assign w_no_gnt    = |(i_alloc_valid & ~w_ok);
  assign w_bad       = w_multi | w_overlap | w_busy_gnt | w_dup_rel | w_not_therm | w_no_gnt;
  always_ff @(posedge i_clock) r_err <= i_reset ? 1'b0 : (r_err | w_bad);
  assign o_err = r_err;
`ifndef SYNTHESIS
  int unsigned r_cyc;
  always_ff @(posedge i_clock) begin
    r_cyc <= i_reset ? 0 : r_cyc + 1;
    if (!i_reset && w_bad)
      $display("rs_free_tracker: cycle %0d protocol error multi=%0b overlap=%0b busy_gnt=%0b dup_rel=%0b not_therm=%0b no_gnt=%0b",
               r_cyc, w_multi, w_overlap, w_busy_gnt, w_dup_rel, w_not_therm, w_no_gnt);
  end
`endif
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: doc/rs_free_tracker.md
Name: rs_free_tracker

Overview:
- Owns the WIDTH-bit free-entry vector of a reservation station (RS).
- Drives `free_vec` into the parallel priority selector. Consumes that selector's per-slot one-hot `gnt_bus` to allocate up to REQS entries per cycle.
- Returns entries freed by issue, and handles flush.
- Reports the free count and a dispatch stall to the dispatch stage.

Parameters:
- WIDTH, 16, number of RS entries (≥ 2).
- REQS, 3, dispatch slots per cycle (1..WIDTH).
- IDX_W, $clog2(WIDTH), derived; entry index width.
- CNT_W, $clog2(WIDTH+1), derived; free-count width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- free_vec  out  WIDTH  registered free bits (1 = free); feeds selector req
- gnt_bus  in  REQS*WIDTH  selector grants; slot k = [(k+1)*WIDTH-1 -: WIDTH], each one-hot or zero
- alloc_valid  in  REQS  slot k dispatches an instruction this cycle
- alloc_ok  out  REQS  slot k has a grant (|slice k), combinational
- alloc_idx  out  REQS*IDX_W  binary index of slot k's grant; 0 when no grant
- release_mask  in  WIDTH  entries issued this cycle, to be freed
- flush  in  1  free all entries
- free_cnt  out  CNT_W  popcount of free_vec, registered
- stall  out  1  free_cnt < REQS, from registered state
- err  out  1  sticky protocol error (only with the optional feature)

Behaviour:
- Reset values: free_vec = all ones; free_cnt = WIDTH; stall = (WIDTH < REQS); err = 0.
- Allocation mask:
  - alloc_mask = OR over k of (slice_k masked by alloc_valid[k]).
  - A slot with alloc_valid = 1 and no grant contributes nothing.
- Next state:
  - flush = 1: free_vec ← all ones (overrides alloc and release).
  - Otherwise: free_vec ← (free_vec & ~alloc_mask) | release_mask.
  - Release wins over alloc on the same bit.
- free_cnt is updated in the same edge to popcount of the next free_vec. It must equal popcount(free_vec) every cycle.
- Latency:
  - An allocated entry reads busy the cycle after alloc.
  - A released entry reads free, and is grantable, the cycle after release.
  - No same-cycle bypass of release into grants.
- stall:
  - Derived only from registered free_cnt.
  - While stall = 1, dispatch holds off all slots. The tracker still honours any alloc_valid presented.
- alloc_idx / alloc_ok are pure functions of gnt_bus (one-hot to binary encoder per slot). They do not depend on alloc_valid.
- alloc_valid is thermometer-coded (slot k valid implies slots < k valid). The tracker does not reorder.
- Boundaries:
  - All free: free_cnt = WIDTH; the CNT_W width must hold it without wrap.
  - All busy: gnt_bus is zero, so allocs are no-ops.
  - Release of an already-free entry leaves it free (idempotent).
  - Flush concurrent with alloc/release yields all free.
  - Reset asserted mid-operation behaves the same as flush, and also clears err.

Optional Feature:
- RS_FREE_TRACKER_CHECK_EN defined: err is set sticky (cleared only by reset) on any of:
  - a grant slice that is not one-hot or zero;
  - two slices overlapping;
  - a grant on an entry whose free_vec bit is 0;
  - release of an entry already free;
  - alloc_valid not thermometer-coded;
  - alloc_valid[k] with alloc_ok[k] = 0.
- Simulation $display reports the cycle and the cause.
- Undefined: err is tied to 0, with no check logic.

Decomposition:
- Shared package rs_pkg: RS_WIDTH, DISPATCH_WIDTH, RS_IDX_W, RS_CNT_W, and the rs_idx_t typedef.
- One sub-module, onehot_enc (WIDTH → IDX_W plus valid), instantiated REQS times.
- Popcount is an in-module function.

Test Plan (WIDTH=8, REQS=3):
- Reset → free_vec = 8'hFF, free_cnt = 8, stall = 0, err = 0.
- gnt slices 8'h01, 8'h02, 8'h04 with alloc_valid = 3'b111 → alloc_idx = {2,1,0}, alloc_ok = 3'b111; next cycle free_vec = 8'hF8, free_cnt = 5.
- From 8'hF8: alloc_valid = 3'b011 with grants 8'h08, 8'h10, 8'h20 → free_vec = 8'hE0, free_cnt = 3, stall = 0. Then alloc 8'h20 → free_vec = 8'hC0, free_cnt = 2, stall = 1.
- From 8'hC0: release_mask = 8'h05 plus alloc of 8'h40 in the same cycle → free_vec = 8'h85, free_cnt = 3, stall = 0.
- From 8'h85: flush = 1 with alloc_valid = 3'b111 → free_vec = 8'hFF, free_cnt = 8. Reset asserted mid-burst gives the same result.
- With RS_FREE_TRACKER_CHECK_EN: release_mask = 8'h01 while free_vec[0] = 1 → err = 1 next cycle, staying 1 until reset; free_vec[0] stays 1.
